// File: rtl/pkt_sched_pkg.sv
// Shared definitions for the packet read scheduler: descriptor layout, FSM states
// and the starvation-guard limit (used only when SCHED_STARVE_GUARD_EN is defined).
package pkt_sched_pkg;

   localparam int unsigned DESC_W       = 20;
   localparam int unsigned LEN_MSB      = 19;
   localparam int unsigned LEN_LSB      = 8;
   localparam int unsigned PRI_MSB      = 7;
   localparam int unsigned PRI_LSB      = 4;
   localparam int unsigned DEST_MSB     = 3;
   localparam int unsigned DEST_LSB     = 0;
   localparam int unsigned STARVE_LIMIT = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      READ = 2'd2
   } sched_state_t;

endpackage

// File: rtl/sched_info_fifo.sv
// Single-clock descriptor FIFO with full/empty/count; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sched_info_fifo
   import pkt_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = DESC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pkt_rd_sched.sv
// Packet read scheduler: per-port descriptor queues, strict-priority/round-robin
// arbiter and read FSM. Define SCHED_STARVE_GUARD_EN to add per-port wait counters.
module pkt_rd_sched
   import pkt_sched_pkg::*;
#(
   parameter int unsigned NUM_PORT   = 4,
   parameter int unsigned INFO_DEPTH = 8,
   parameter int unsigned DATA_W     = 8
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic [NUM_PORT-1:0]          info_vld,
   input  logic [NUM_PORT*DESC_W-1:0]   info_data,
   output logic [NUM_PORT-1:0]          info_full,
   output logic [NUM_PORT-1:0]          info_ovf,
   output logic [NUM_PORT-1:0]          data_ren,
   input  logic [NUM_PORT*DATA_W-1:0]   data_in,
   input  logic                         out_rdy,
   output logic                         out_vld,
   output logic                         out_sop,
   output logic                         out_eop,
   output logic [DATA_W-1:0]            out_data,
   output logic [3:0]                   out_dest,
   output logic [3:0]                   out_pri,
   output logic                         busy
);

   localparam int unsigned PW = $clog2(NUM_PORT);
   localparam int unsigned CW = $clog2(INFO_DEPTH) + 1;

   sched_state_t        state;
   logic [NUM_PORT-1:0] q_empty;
   logic [NUM_PORT-1:0] q_full;
   logic [NUM_PORT-1:0] q_pop;
   logic [CW-1:0]       q_cnt  [NUM_PORT];
   logic [11:0]         h_len  [NUM_PORT];
   logic [3:0]          h_pri  [NUM_PORT];
   logic [3:0]          h_dest [NUM_PORT];

   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       arb_port;
   logic [PW-1:0]       grant_port;
   logic [3:0]          arb_pri;
   logic                arb_found;
   logic [PW:0]         cand;
   logic                any_pending;
   logic                more_after_pop;

   logic [PW-1:0]       g_port;
   logic [11:0]         g_len;
   logic [3:0]          g_pri;
   logic [3:0]          g_dest;
   logic [11:0]         rd_cnt;
   logic [PW-1:0]       out_port;
   logic                issue;
   logic                last_rd;

   for (genvar p = 0; p < NUM_PORT; p++) begin : g_q
      logic [DESC_W-1:0] rdata;

      sched_info_fifo #(
         .DEPTH (INFO_DEPTH),
         .WIDTH (DESC_W)
      ) u_fifo (
         .clk   (sys_clk),
         .rst_n (sys_rst_n),
         .push  (info_vld[p]),
         .pop   (q_pop[p]),
         .wdata (info_data[p*DESC_W +: DESC_W]),
         .rdata (rdata),
         .full  (q_full[p]),
         .empty (q_empty[p]),
         .count (q_cnt[p])
      );

      assign h_len[p]  = rdata[LEN_MSB:LEN_LSB];
      assign h_pri[p]  = rdata[PRI_MSB:PRI_LSB];
      assign h_dest[p] = rdata[DEST_MSB:DEST_LSB];
   end

   assign info_full   = q_full;
   assign any_pending = |(~q_empty);
   assign busy        = (state != IDLE);
   assign issue       = (state == READ) && out_rdy;
   assign last_rd     = (rd_cnt == g_len - 12'd1);

   // Scan from rr_ptr+1 upward; only a strictly higher pri displaces the first hit,
   // so ties resolve to the port closest after the last grant.
   always_comb begin
      arb_found = 1'b0;
      arb_port  = '0;
      arb_pri   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_PORT; i++) begin
         cand = (PW+1)'(rr_ptr) + (PW+1)'(i);
         if (cand >= (PW+1)'(NUM_PORT)) cand = cand - (PW+1)'(NUM_PORT);
         if (!q_empty[cand[PW-1:0]] &&
             (!arb_found || h_pri[cand[PW-1:0]] > arb_pri)) begin
            arb_found = 1'b1;
            arb_port  = cand[PW-1:0];
            arb_pri   = h_pri[cand[PW-1:0]];
         end
      end
   end

`ifdef SCHED_STARVE_GUARD_EN
   logic [7:0]    wait_cnt [NUM_PORT];
   logic          starve_hit;
   logic [PW-1:0] starve_port;

   always_comb begin
      starve_hit  = 1'b0;
      starve_port = '0;
      for (int unsigned p = 0; p < NUM_PORT; p++) begin
         if (!starve_hit && !q_empty[p] && wait_cnt[p] == 8'(STARVE_LIMIT)) begin
            starve_hit  = 1'b1;
            starve_port = PW'(p);
         end
      end
   end

   assign grant_port = starve_hit ? starve_port : arb_port;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int unsigned p = 0; p < NUM_PORT; p++) wait_cnt[p] <= '0;
      end else if (state == ARB && any_pending) begin
         for (int unsigned p = 0; p < NUM_PORT; p++) begin
            if (PW'(p) == grant_port)
               wait_cnt[p] <= '0;
            else if (!q_empty[p] && wait_cnt[p] != 8'(STARVE_LIMIT))
               wait_cnt[p] <= wait_cnt[p] + 8'd1;
         end
      end
   end
`else
   assign grant_port = arb_port;
`endif

   assign q_pop = (state == ARB && any_pending) ? (NUM_PORT'(1) << grant_port) : '0;

   // Queue state as it will be after this ARB's pop; same-cycle pushes are seen next cycle.
   assign more_after_pop = (|(~q_empty & ~q_pop)) || (q_cnt[grant_port] > CW'(1));

   always_comb begin
      data_ren = '0;
      if (issue) data_ren = NUM_PORT'(1) << g_port;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         info_ovf <= '0;
      end else begin
         info_ovf <= info_ovf | (info_vld & q_full & ~q_pop);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         g_port   <= '0;
         g_len    <= '0;
         g_pri    <= '0;
         g_dest   <= '0;
         rd_cnt   <= '0;
         out_vld  <= 1'b0;
         out_sop  <= 1'b0;
         out_eop  <= 1'b0;
         out_dest <= '0;
         out_pri  <= '0;
         out_port <= '0;
      end else begin
         out_vld <= issue;
         out_sop <= issue && (rd_cnt == '0);
         out_eop <= issue && last_rd;
         if (issue) begin
            out_dest <= g_dest;
            out_pri  <= g_pri;
            out_port <= g_port;
         end

         unique case (state)
            IDLE: begin
               if (any_pending) state <= ARB;
            end
            ARB: begin
               if (!any_pending) begin
                  state <= IDLE;
               end else begin
                  g_port <= grant_port;
                  g_len  <= h_len[grant_port];
                  g_pri  <= h_pri[grant_port];
                  g_dest <= h_dest[grant_port];
                  rr_ptr <= grant_port;
                  rd_cnt <= '0;
                  if (h_len[grant_port] == '0)
                     state <= more_after_pop ? ARB : IDLE;
                  else
                     state <= READ;
               end
            end
            READ: begin
               if (out_rdy) begin
                  if (last_rd) begin
                     rd_cnt <= '0;
                     state  <= any_pending ? ARB : IDLE;
                  end else begin
                     rd_cnt <= rd_cnt + 12'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The ingress FIFO has one cycle of read latency, so the byte arrives alongside the
   // registered out_vld; it is steered by the port latched with that beat.
   assign out_data = out_vld ? data_in[out_port*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_pkt_rd_sched.sv
// Self-checking bench for pkt_rd_sched: latency table, hand-written corner cases and
// randomized batches checked against a queue-based scheduling model.
module tb_pkt_rd_sched;

   localparam int NP    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic [NP-1:0]     info_vld;
   logic [NP*20-1:0]  info_data;
   logic [NP-1:0]     info_full;
   logic [NP-1:0]     info_ovf;
   logic [NP-1:0]     data_ren;
   logic [NP*DW-1:0]  data_in;
   logic              out_rdy;
   logic              out_vld;
   logic              out_sop;
   logic              out_eop;
   logic [DW-1:0]     out_data;
   logic [3:0]        out_dest;
   logic [3:0]        out_pri;
   logic              busy;

   pkt_rd_sched #(
      .NUM_PORT   (NP),
      .INFO_DEPTH (DEPTH),
      .DATA_W     (DW)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .info_vld  (info_vld),
      .info_data (info_data),
      .info_full (info_full),
      .info_ovf  (info_ovf),
      .data_ren  (data_ren),
      .data_in   (data_in),
      .out_rdy   (out_rdy),
      .out_vld   (out_vld),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_data  (out_data),
      .out_dest  (out_dest),
      .out_pri   (out_pri),
      .busy      (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] pat(input int p, input int idx);
      return DW'(p * 53 + idx * 7 + 1);
   endfunction

   // Ingress FIFO stand-in: each port streams pat(p, 0), pat(p, 1), ... one cycle after ren.
   int rd_idx [NP];
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int p = 0; p < NP; p++) rd_idx[p] <= 0;
         data_in <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (data_ren[p]) begin
               data_in[p*DW +: DW] <= pat(p, rd_idx[p]);
               rd_idx[p] <= rd_idx[p] + 1;
            end
         end
      end
   end

   typedef struct {
      int port;
      int len;
      int pri;
      int dest;
   } pkt_t;

   pkt_t exp_q [$];
   pkt_t mon_e;
   int   exp_idx [NP];
   int   beat;

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         exp_q.delete();
         beat = 0;
         for (int p = 0; p < NP; p++) exp_idx[p] = 0;
      end else begin
         if (data_ren != '0) chk("ren_onehot", 64'($countones(data_ren)), 64'(1));
         if (out_vld) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_beat: got data %0h dest %0h expected no beat at %0t",
                        out_data, out_dest, $time);
            end else begin
               mon_e = exp_q[0];
               chk("beat", 64'({out_sop, out_eop, out_data, out_dest, out_pri}),
                   64'({beat == 0, beat == mon_e.len - 1, pat(mon_e.port, exp_idx[mon_e.port]),
                        4'(mon_e.dest), 4'(mon_e.pri)}));
               exp_idx[mon_e.port]++;
               beat++;
               if (beat == mon_e.len) begin
                  beat = 0;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_desc(input int p, input int len, input int pri, input int dest);
      info_vld[p] = 1'b1;
      info_data[p*20 +: 20] = {12'(len), 4'(pri), 4'(dest)};
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while ((busy || out_vld || exp_q.size() != 0) && k < budget) begin
         tick();
         k++;
      end
      chk(name, 64'(k < budget), 64'(1));
   endtask

   typedef struct {
      int port;
      int len;
      int pri;
      int dest;
      int e_first_ren;
      int e_nren;
      int e_sop;
      int e_eop;
      int e_dest;
   } vec_t;

   vec_t vt [4];
   pkt_t mq [NP][$];
   pkt_t me;
   int   ovf_len [9] = '{2, 0, 1, 3, 0, 1, 2, 1, 4};
   int   fr, nr, sk, ek, ds, nb, nlow, ns, ne, last2, first0, base, best, blk, bl, k;
   logic b1, b2;
   int   cnt [NP];
   int   model_rr;
   logic [NP-1:0] m_ovf;
   logic [NP-1:0] m_full;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1);
   end

   initial begin
      sys_rst_n = 1'b0;
      info_vld  = '0;
      info_data = '0;
      out_rdy   = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("reset_outputs", 64'({data_ren, info_full, info_ovf, out_vld, out_sop, out_eop,
                                out_data, out_dest, out_pri, busy}), 64'(0));
      sys_rst_n = 1'b1;
      tick();

      // Equal priority on all ports: round-robin from rr_ptr=0 gives 1,2,3,0,1,2,3,0.
      for (int j = 0; j < 8; j++)
         exp_q.push_back('{(j + 1) % 4, 1 + (j + 1) % 4 + j / 4, 4, (j + 1) % 4 + 4 * (j / 4)});
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NP; p++) set_desc(p, 1 + p + r, 4, p + 4 * r);
         tick();
      end
      info_vld = '0;
      repeat (3) tick();
      wait_idle("rr_drain", 400);

      vt[0] = '{1, 5, 2, 3,   3, 5, 4, 8, 3};
      vt[1] = '{0, 1, 7, 9,   3, 1, 4, 4, 9};
      vt[2] = '{3, 3, 15, 12, 3, 3, 4, 6, 12};
      vt[3] = '{2, 0, 4, 1,  -1, 0, -1, -1, -1};
      for (int v = 0; v < 4; v++) begin
         fr = -1; nr = 0; sk = -1; ek = -1; ds = -1; b1 = 1'b0; b2 = 1'b0;
         if (vt[v].len > 0) exp_q.push_back('{vt[v].port, vt[v].len, vt[v].pri, vt[v].dest});
         set_desc(vt[v].port, vt[v].len, vt[v].pri, vt[v].dest);
         for (int c = 0; c < 16; c++) begin
            @(negedge sys_clk);
            if (data_ren[vt[v].port]) begin
               if (fr < 0) fr = c;
               nr++;
            end
            if (out_vld && out_sop) begin
               sk = c;
               ds = int'(out_dest);
            end
            if (out_vld && out_eop) ek = c;
            if (c == 1) b1 = busy;
            if (c == 2) b2 = busy;
            @(posedge sys_clk);
            #1;
            info_vld = '0;
         end
         chk("vec_first_ren", 64'(fr), 64'(vt[v].e_first_ren));
         chk("vec_nren", 64'(nr), 64'(vt[v].e_nren));
         chk("vec_sop", 64'(sk), 64'(vt[v].e_sop));
         chk("vec_eop", 64'(ek), 64'(vt[v].e_eop));
         chk("vec_dest", 64'(ds), 64'(vt[v].e_dest));
         chk("vec_busy_idle_arb", 64'({b1, b2}), 64'(2'b01));
      end

      // Priority 6 on port 2 beats priority 1 on port 0; one ARB cycle separates them.
      exp_q.push_back('{2, 3, 6, 5});
      exp_q.push_back('{0, 2, 1, 7});
      set_desc(0, 2, 1, 7);
      set_desc(2, 3, 6, 5);
      last2 = -1; first0 = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge sys_clk);
         if (data_ren[2]) last2 = c;
         if (data_ren[0] && first0 < 0) first0 = c;
         @(posedge sys_clk);
         #1;
         info_vld = '0;
      end
      chk("gap_order", 64'(first0 > last2), 64'(1));
      chk("gap_cycles", 64'(first0 - last2), 64'(2));

      // Backpressure: out_rdy low for 3 cycles in the middle of a 10-beat packet.
      exp_q.push_back('{3, 10, 8, 6});
      set_desc(3, 10, 8, 6);
      nr = 0; nb = 0; nlow = 0; ns = 0; ne = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge sys_clk);
         if (data_ren[3]) nr++;
         if (out_vld) begin
            nb++;
            if (!out_rdy) nlow++;
            if (out_sop) ns++;
            if (out_eop) ne++;
         end
         @(posedge sys_clk);
         #1;
         info_vld = '0;
         out_rdy  = !((c + 1) >= 7 && (c + 1) < 10);
      end
      out_rdy = 1'b1;
      chk("bp_nren", 64'(nr), 64'(10));
      chk("bp_beats", 64'(nb), 64'(10));
      chk("bp_inflight", 64'(nlow <= 1), 64'(1));
      chk("bp_sop_eop", 64'({8'(ns), 8'(ne)}), 64'({8'd1, 8'd1}));

      // Overflow: port 1 holds the FSM in READ with out_rdy low while port 0 gets 9 pushes.
      exp_q.push_back('{1, 2, 5, 1});
      out_rdy = 1'b0;
      set_desc(1, 2, 5, 1);
      tick();
      info_vld = '0;
      repeat (4) tick();
      chk("ovf_blocked_busy", 64'(busy), 64'(1));
      base = rd_idx[0];
      for (int i = 0; i < 9; i++) begin
         set_desc(0, ovf_len[i], 3, i);
         if (ovf_len[i] > 0 && i < 8) exp_q.push_back('{0, ovf_len[i], 3, i});
         tick();
         info_vld = '0;
         if (i == 6) chk("full_after_7", 64'({info_full[0], info_ovf[0]}), 64'(2'b00));
         if (i == 7) chk("full_after_8", 64'({info_full[0], info_ovf[0]}), 64'(2'b10));
         if (i == 8) chk("ovf_after_9", 64'({info_full[0], info_ovf[0]}), 64'(2'b11));
      end
      out_rdy = 1'b1;
      repeat (2) tick();
      wait_idle("ovf_drain", 300);
      chk("ovf_reads", 64'(rd_idx[0] - base), 64'(10));
      chk("ovf_sticky", 64'({info_ovf, info_full}), 64'({4'b0001, 4'b0000}));

      // Reset in the middle of a read: outputs drop at once, queued work is discarded.
      exp_q.push_back('{2, 20, 9, 4});
      set_desc(2, 20, 9, 4);
      set_desc(1, 3, 2, 2);
      tick();
      info_vld = '0;
      repeat (6) tick();
      chk("rst_pre_ren", 64'(data_ren[2]), 64'(1));
      sys_rst_n = 1'b0;
      #1;
      chk("rst_async", 64'({data_ren, out_vld, busy}), 64'(0));
      repeat (2) tick();
      sys_rst_n = 1'b1;
      nr = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge sys_clk);
         if (data_ren != '0 || busy || out_vld) nr++;
      end
      chk("rst_queues_empty", 64'(nr), 64'(0));
      chk("rst_flags", 64'({info_full, info_ovf}), 64'(0));
      tick();

      // Randomized batches: queue descriptors behind a stalled packet, then drain.
      model_rr = 0;
      m_ovf = '0;
      for (int round = 0; round < 6; round++) begin
         blk = $urandom_range(0, NP - 1);
         bl  = $urandom_range(1, 4);
         exp_q.push_back('{blk, bl, 2, 15});
         out_rdy = 1'b0;
         set_desc(blk, bl, 2, 15);
         tick();
         info_vld = '0;
         repeat (4) tick();
         model_rr = blk;
         for (int p = 0; p < NP; p++) cnt[p] = $urandom_range(0, 9);
         for (int s = 0; s < 9; s++) begin
            for (int p = 0; p < NP; p++) begin
               if (s < cnt[p]) begin
                  me = '{p, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 15))};
                  set_desc(p, me.len, me.pri, me.dest);
                  if (mq[p].size() == DEPTH) m_ovf[p] = 1'b1;
                  else mq[p].push_back(me);
               end
            end
            tick();
            info_vld = '0;
         end
         for (int p = 0; p < NP; p++) m_full[p] = (mq[p].size() == DEPTH);
         chk("rnd_full", 64'(info_full), 64'(m_full));
         chk("rnd_ovf", 64'(info_ovf), 64'(m_ovf));
         for (int n = 0; n < NP * DEPTH + 1; n++) begin
            best = -1;
            for (int i = 1; i <= NP; i++) begin
               k = (model_rr + i) % NP;
               if (mq[k].size() > 0 && (best < 0 || mq[k][0].pri > mq[best][0].pri)) best = k;
            end
            if (best < 0) break;
            me = mq[best].pop_front();
            model_rr = best;
            if (me.len > 0) exp_q.push_back(me);
         end
         k = 0;
         while ((busy || out_vld || exp_q.size() != 0) && k < 3000) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
            k++;
         end
         out_rdy = 1'b1;
         chk("rnd_drain", 64'(k < 3000), 64'(1));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
